game_tick_ctrl: RTL and testbench

Game timing scheduler for the Dino game. It produces single-cycle enable strobes from the system clock: a fixed display-scan strobe, a game frame tick whose period shortens as play continues, and a blink level for pause/game-over indication. It sequences the game phase (idle/run/pause/over) from start, pause and collision inputs. It sits between the board clock and the display, obstacle and dino logic, and replaces divided clocks with clock enables on the single `clk` domain.

---
 rtl/game_timing_pkg.sv | 32 +++
 rtl/strobe_gen.sv | 39 +++
 rtl/game_tick_ctrl.sv | 166 ++++++++++++++++
 tb/tb_game_tick_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/game_timing_pkg.sv
// Shared timing constants, game phase encoding and counter sizing helper
// for the Dino game tick scheduler.
package game_timing_pkg;

   // Game phase encoding as seen on the state output.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_OVER  = 2'd3
   } state_t;

   // Board defaults for a 100 MHz system clock.
   localparam int DEF_SCAN_DIV       = 100_000;
   localparam int DEF_FRAME_DIV_INIT = 2_000_000;
   localparam int DEF_FRAME_DIV_MIN  = 800_000;
   localparam int DEF_FRAME_DIV_STEP = 50_000;
   localparam int DEF_SPEEDUP_FRAMES = 500;
   localparam int DEF_BLINK_DIV      = 25_000_000;

   localparam int FRAME_W = 32;
   localparam int LEVEL_W = 5;

   // Width of a counter that must be able to hold the value n itself
   // (the modulus is carried on the same bus as the count).
   function automatic int cnt_width(input int n);
      int w;
      w = $clog2(n + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/strobe_gen.sv
// Modulus counter producing a registered one-cycle strobe on every wrap.
// The count advances only while en is high; clr (or rst) returns it to 0.
module strobe_gen #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] modulus,
   output logic         strobe
);

   logic [W-1:0] cnt;
   logic         at_end;

   // >= rather than == so a modulus lowered below the current count
   // still wraps instead of running all the way round the counter.
   assign at_end = (cnt >= (modulus - W'(1)));

   // Count, wrap, and register the strobe one cycle after the wrap point.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt    <= '0;
         strobe <= 1'b0;
      end else if (en) begin
         if (at_end) begin
            cnt    <= '0;
            strobe <= 1'b1;
         end else begin
            cnt    <= cnt + W'(1);
            strobe <= 1'b0;
         end
      end else begin
         strobe <= 1'b0;
      end
   end

endmodule

// File: rtl/game_tick_ctrl.sv
// Dino game timing scheduler: display-scan strobe, accelerating frame tick,
// pause/game-over blink level and the idle/run/pause/over phase machine.
// Everything runs on clk using clock enables; all outputs are registered.
module game_tick_ctrl
   import game_timing_pkg::*;
#(
   parameter int SCAN_DIV       = DEF_SCAN_DIV,
   parameter int FRAME_DIV_INIT = DEF_FRAME_DIV_INIT,
   parameter int FRAME_DIV_MIN  = DEF_FRAME_DIV_MIN,
   parameter int FRAME_DIV_STEP = DEF_FRAME_DIV_STEP,
   parameter int SPEEDUP_FRAMES = DEF_SPEEDUP_FRAMES,
   parameter int BLINK_DIV      = DEF_BLINK_DIV
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                pause_btn,
   input  logic                collide,
   output logic                scan_tick,
   output logic                frame_tick,
   output logic                blink,
   output logic [1:0]          state,
   output logic [LEVEL_W-1:0]  speed_level,
   output logic [FRAME_W-1:0]  frame_period
);

   localparam int SCAN_W  = cnt_width(SCAN_DIV);
   localparam int BLINK_W = cnt_width(BLINK_DIV);
   localparam int TICK_W  = cnt_width(SPEEDUP_FRAMES);

   localparam logic [FRAME_W-1:0] P_INIT = FRAME_W'(FRAME_DIV_INIT);
   localparam logic [FRAME_W-1:0] P_MIN  = FRAME_W'(FRAME_DIV_MIN);
   localparam logic [FRAME_W-1:0] P_STEP = FRAME_W'(FRAME_DIV_STEP);
   localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(SPEEDUP_FRAMES - 1);
   localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;

   state_t               state_q;
   logic [FRAME_W-1:0]   period_q;
   logic [LEVEL_W-1:0]   level_q;
   logic [TICK_W-1:0]    tick_q;
   logic                 blink_q;

   logic                 in_run;
   logic                 in_hold;
   logic                 in_rest;
   logic                 blink_strobe;
   logic [FRAME_W-1:0]   period_dec;
   logic                 lowered;

   assign in_run  = (state_q == S_RUN);
   assign in_hold = (state_q == S_PAUSE) || (state_q == S_OVER);
   assign in_rest = (state_q == S_IDLE)  || (state_q == S_OVER);

   // Display scan runs regardless of the game phase.
   strobe_gen #(.W(SCAN_W)) u_scan (
      .clk     (clk),
      .rst     (rst),
      .en      (1'b1),
      .clr     (1'b0),
      .modulus (SCAN_W'(SCAN_DIV)),
      .strobe  (scan_tick)
   );

   // Frame counter: a collision in RUN freezes it so the wrap cycle emits
   // no tick; the phase machine then moves to OVER which clears it.
   strobe_gen #(.W(FRAME_W)) u_frame (
      .clk     (clk),
      .rst     (rst),
      .en      (in_run && !collide),
      .clr     (in_rest),
      .modulus (period_q),
      .strobe  (frame_tick)
   );

   // Blink timebase only runs while paused or game over.
   strobe_gen #(.W(BLINK_W)) u_blink (
      .clk     (clk),
      .rst     (rst),
      .en      (in_hold),
      .clr     (!in_hold),
      .modulus (BLINK_W'(BLINK_DIV)),
      .strobe  (blink_strobe)
   );

   // Next shorter frame period, floored at the minimum; compared before
   // subtracting so the period can never wrap below zero.
   always_comb begin
      period_dec = P_MIN;
      if (period_q >= (P_MIN + P_STEP)) begin
         period_dec = period_q - P_STEP;
      end
      lowered = (period_dec < period_q);
   end

   // Phase machine plus speed-up and blink registers. The speed-up acts on
   // the registered frame tick, i.e. during the first cycle of the new
   // frame, so the shorter period governs that frame's wrap. Restart
   // assignments come last so they win over a coincident speed-up.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         period_q <= P_INIT;
         level_q  <= '0;
         tick_q   <= '0;
         blink_q  <= 1'b1;
      end else begin
         if (frame_tick) begin
            if (tick_q == TICK_LAST) begin
               tick_q   <= '0;
               period_q <= period_dec;
               if (lowered && (level_q != LEVEL_MAX)) begin
                  level_q <= level_q + LEVEL_W'(1);
               end
            end else begin
               tick_q <= tick_q + TICK_W'(1);
            end
         end

         if (in_hold && blink_strobe) begin
            blink_q <= ~blink_q;
         end

         case (state_q)
            S_IDLE: begin
               blink_q <= 1'b1;
               if (start) begin
                  state_q  <= S_RUN;
                  period_q <= P_INIT;
                  level_q  <= '0;
                  tick_q   <= '0;
               end
            end
            S_RUN: begin
               blink_q <= 1'b1;
               if (collide) begin
                  state_q <= S_OVER;
               end else if (pause_btn) begin
                  state_q <= S_PAUSE;
               end
            end
            S_PAUSE: begin
               if (pause_btn || start) begin
                  state_q <= S_RUN;
                  blink_q <= 1'b1;
               end
            end
            S_OVER: begin
               if (start) begin
                  state_q  <= S_RUN;
                  blink_q  <= 1'b1;
                  period_q <= P_INIT;
                  level_q  <= '0;
                  tick_q   <= '0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign state        = state_q;
   assign speed_level  = level_q;
   assign frame_period = period_q;
   assign blink        = blink_q;

endmodule

// File: tb/tb_game_tick_ctrl.sv
// Bench for game_tick_ctrl with scaled dividers. A behavioural model
// tracks phase, elapsed run time per frame, frame count, period and the
// length of the current pause/over stretch; every cycle all outputs are
// compared to it, plus directed checks on tick spacing and reset values.
module tb_game_tick_ctrl;

   localparam int SCAN_DIV = 4;
   localparam int P_INIT   = 20;
   localparam int P_MIN    = 12;
   localparam int P_STEP   = 4;
   localparam int SPF      = 2;
   localparam int BLINK    = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        pause_btn = 1'b0;
   logic        collide = 1'b0;
   logic        scan_tick;
   logic        frame_tick;
   logic        blink;
   logic [1:0]  state;
   logic [4:0]  speed_level;
   logic [31:0] frame_period;

   int n_vec = 0;
   int n_err = 0;

   // reference model
   int m_st, m_el, m_per, m_lvl, m_frames, m_n, m_hold;
   bit m_ftick;

   game_tick_ctrl #(
      .SCAN_DIV       (SCAN_DIV),
      .FRAME_DIV_INIT (P_INIT),
      .FRAME_DIV_MIN  (P_MIN),
      .FRAME_DIV_STEP (P_STEP),
      .SPEEDUP_FRAMES (SPF),
      .BLINK_DIV      (BLINK)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .pause_btn    (pause_btn),
      .collide      (collide),
      .scan_tick    (scan_tick),
      .frame_tick   (frame_tick),
      .blink        (blink),
      .state        (state),
      .speed_level  (speed_level),
      .frame_period (frame_period)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Blink: 1 outside pause/over; inside, first toggle shows in the 5th
   // held cycle and then every BLINK cycles.
   function automatic bit exp_blink();
      if (m_hold < 2) return 1'b1;
      return (((m_hold - 2) / BLINK) % 2) == 0;
   endfunction

   function automatic bit exp_scan();
      return (m_n > 0) && ((m_n % SCAN_DIV) == 0);
   endfunction

   task automatic model_edge(input bit s, input bit p, input bit c, input bit r);
      int nst;
      bit nft;
      if (r) begin
         m_st = 0; m_el = 0; m_per = P_INIT; m_lvl = 0; m_frames = 0;
         m_n = 0; m_hold = 0; m_ftick = 1'b0;
         return;
      end
      m_n++;
      nft = 1'b0;
      if (m_st == 1 && !c) begin
         m_el++;
         if (m_el == m_per) begin
            m_el = 0;
            nft = 1'b1;
         end
      end else if (m_st == 0 || m_st == 3) begin
         m_el = 0;
      end
      if (m_ftick) begin
         m_frames++;
         if (m_frames == SPF) begin
            m_frames = 0;
            if (m_per > P_MIN) begin
               m_per = (m_per - P_STEP < P_MIN) ? P_MIN : m_per - P_STEP;
               if (m_lvl < 31) m_lvl++;
            end
         end
      end
      nst = m_st;
      case (m_st)
         0: if (s) nst = 1;
         1: if (c) nst = 3; else if (p) nst = 2;
         2: if (p || s) nst = 1;
         default: if (s) nst = 1;
      endcase
      if ((m_st == 0 || m_st == 3) && nst == 1) begin
         m_per = P_INIT; m_lvl = 0; m_frames = 0; m_el = 0;
      end
      m_hold = (nst == 2 || nst == 3) ? m_hold + 1 : 0;
      m_st = nst;
      m_ftick = nft;
   endtask

   task automatic cycle(input bit s, input bit p, input bit c, input bit r);
      start = s; pause_btn = p; collide = c; rst = r;
      @(posedge clk);
      model_edge(s, p, c, r);
      #1;
      chk("scan_tick", 32'(scan_tick), 32'(exp_scan()));
      chk("frame_tick", 32'(frame_tick), 32'(m_ftick));
      chk("blink", 32'(blink), 32'(exp_blink()));
      chk("state", 32'(state), 32'(m_st));
      chk("speed_level", 32'(speed_level), 32'(m_lvl));
      chk("frame_period", frame_period, 32'(m_per));
   endtask

   task automatic wait_tick(input int limit, output int cyc);
      cyc = 0;
      do begin
         cycle(1'b0, 1'b0, 1'b0, 1'b0);
         cyc++;
      end while (!frame_tick && cyc < limit);
      chk("tick_seen", 32'(frame_tick), 32'd1);
   endtask

   initial begin
      int cyc;
      int exp_iv[6];
      int toggles;
      bit prev_b;
      exp_iv = '{20, 20, 16, 16, 12, 12};

      // reset and idle with ignored pause/collide noise
      repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b1);
      chk("reset_period", frame_period, 32'd20);
      chk("reset_blink", 32'(blink), 32'd1);
      for (int i = 0; i < 40; i++) begin
         cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      end
      chk("idle_state", 32'(state), 32'd0);

      // six frames with speed-up
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         wait_tick(100, cyc);
         chk($sformatf("frame_gap%0d", i), 32'(cyc), 32'(exp_iv[i]));
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      chk("floor_period", frame_period, 32'd12);
      chk("floor_level", 32'(speed_level), 32'd2);

      // collide and pause together: collide wins
      repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 1'b1, 1'b0);
      chk("collide_prio", 32'(state), 32'd3);
      repeat (8) cycle(1'b0, 1'b0, 1'b0, 1'b0);

      // restart from OVER
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      chk("restart_state", 32'(state), 32'd1);
      chk("restart_period", frame_period, 32'd20);
      chk("restart_level", 32'(speed_level), 32'd0);
      wait_tick(100, cyc);
      chk("restart_gap", 32'(cyc), 32'd20);

      // pause mid-frame: 7 run cycles, 10 paused, remaining 13 run cycles
      repeat (6) cycle(1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      chk("paused", 32'(state), 32'd2);
      toggles = 0;
      prev_b = blink;
      for (int i = 0; i < 9; i++) begin
         cycle(1'b0, 1'b0, 1'b0, 1'b0);
         if (blink != prev_b) toggles++;
         prev_b = blink;
      end
      chk("pause_toggles", 32'(toggles), 32'd2);
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      chk("resumed", 32'(state), 32'd1);
      wait_tick(100, cyc);
      chk("pause_gap", 32'(cyc), 32'd13);

      // collide exactly on the wrap cycle
      for (int g = 0; g < 100 && !(m_st == 1 && m_el == m_per - 1); g++) begin
         cycle(1'b0, 1'b0, 1'b0, 1'b0);
      end
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      chk("wrap_collide_tick", 32'(frame_tick), 32'd0);
      chk("wrap_collide_state", 32'(state), 32'd3);
      repeat (5) cycle(1'b0, 1'b0, 1'b0, 1'b0);

      // reset mid-run at level 2
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) wait_tick(100, cyc);
      repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0);
      chk("pre_rst_level", 32'(speed_level), 32'd2);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_period", frame_period, 32'd20);
      chk("rst_level", 32'(speed_level), 32'd0);
      chk("rst_frame_tick", 32'(frame_tick), 32'd0);
      chk("rst_scan_tick", 32'(scan_tick), 32'd0);
      chk("rst_blink", 32'(blink), 32'd1);

      // randomized play
      for (int i = 0; i < 1500; i++) begin
         cycle(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0),
               1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 399) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
